// File: rtl/sumres_serial_ctrl.sv
// Bit-serial 4-bit add/subtract sequencer with sign/magnitude result hold
// and a free-running two-digit display scan generator.
module sumres_serial_ctrl #(
  parameter int WIDTH    = 4,
  parameter int SCAN_DIV = 100
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             sign0,
  output logic             dis0,
  output logic             dis1
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, work_q, result_q;
  logic [BW-1:0]    bit_cnt_q;
  logic             op_q, c_q, eff_op_q, sign_n_q;
  logic             carry_out_q, sign0_q;
  logic [CW-1:0]    scan_cnt_q;
  logic             digit_q;

  // The single shared full-adder cell, fed from the operand LSBs.
  logic sum_bit, carry_next, last_bit;
  assign sum_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_next = (a_q[0] & b_q[0]) | ((a_q[0] | b_q[0]) & c_q);
  assign last_bit   = (bit_cnt_q == BW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  begin busy = 1'b1; state_d = S_SHIFT; end
      S_SHIFT: begin busy = 1'b1; if (last_bit) state_d = S_DONE; end
      S_DONE:  begin done = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, sign/magnitude setup, serial add and result hold.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      result_q    <= '0;
      bit_cnt_q   <= '0;
      op_q        <= 1'b0;
      c_q         <= 1'b0;
      eff_op_q    <= 1'b0;
      sign_n_q    <= 1'b1;
      carry_out_q <= 1'b0;
      sign0_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q  <= in_a;
            b_q  <= in_b;
            op_q <= op;
          end
        end
        S_LOAD: begin
          bit_cnt_q <= '0;
          work_q    <= '0;
          if (op_q && (a_q < b_q)) begin
            // Swap so the larger magnitude is the minuend; result is negative.
            a_q      <= b_q;
            b_q      <= ~a_q;
            c_q      <= 1'b1;
            eff_op_q <= 1'b1;
            sign_n_q <= 1'b0;
          end else if (op_q && (a_q == b_q)) begin
            // Equal operands: add zero to zero so the answer is +0.
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            eff_op_q <= 1'b0;
            sign_n_q <= 1'b1;
          end else if (op_q) begin
            b_q      <= ~b_q;
            c_q      <= 1'b1;
            eff_op_q <= 1'b1;
            sign_n_q <= 1'b1;
          end else begin
            c_q      <= 1'b0;
            eff_op_q <= 1'b0;
            sign_n_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          a_q       <= a_q >> 1;
          b_q       <= b_q >> 1;
          c_q       <= carry_next;
          work_q    <= {sum_bit, work_q[WIDTH-1:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (last_bit) begin
            result_q    <= {sum_bit, work_q[WIDTH-1:1]};
            carry_out_q <= carry_next & ~eff_op_q;
            sign0_q     <= sign_n_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scan: toggle the selected digit every SCAN_DIV cycles.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= 1'b0;
    end else if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      digit_q    <= ~digit_q;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign sign0     = sign0_q;
  assign dis0      = ~digit_q;
  assign dis1      = digit_q;

endmodule

// File: tb/tb_sumres_serial_ctrl.sv
// Self-checking bench for sumres_serial_ctrl: arithmetic reference model,
// per-cycle output comparison, directed cases and randomized operations.
module tb_sumres_serial_ctrl;

  localparam int W  = 4;
  localparam int SD = 4;

  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic         op     = 1'b0;
  logic [W-1:0] in_a   = '0;
  logic [W-1:0] in_b   = '0;
  logic         busy, done, carry_out, sign0, dis0, dis1;
  logic [W-1:0] result;

  sumres_serial_ctrl #(.WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .sign0    (sign0),
    .dis0     (dis0),
    .dis1     (dis1)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int dut_dones = 0;
  bit en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         sign;
  } exp_t;

  // Arithmetic meaning of one operation, straight from integers.
  function automatic exp_t ref_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa = int'(a);
    int sb = int'(b);
    if (!o) begin
      e.res   = W'((sa + sb) % (1 << W));
      e.carry = ((sa + sb) >= (1 << W));
      e.sign  = 1'b1;
    end else if (sa >= sb) begin
      e.res = W'(sa - sb); e.carry = 1'b0; e.sign = 1'b1;
    end else begin
      e.res = W'(sb - sa); e.carry = 1'b0; e.sign = 1'b0;
    end
    return e;
  endfunction

  // Model: m_age = edges since the accepting edge (0 = idle).
  int   m_age   = 0;
  int   m_edges = 0;
  exp_t m_out   = '{res: '0, carry: 1'b0, sign: 1'b1};
  exp_t m_pend  = '{res: '0, carry: 1'b0, sign: 1'b1};

  always @(posedge clk_in) begin
    if (rst) begin
      m_age   <= 0;
      m_edges <= 0;
      m_out   <= '{res: '0, carry: 1'b0, sign: 1'b1};
    end else begin
      m_edges <= m_edges + 1;
      if (m_age == 0) begin
        if (start === 1'b1) begin
          m_age  <= 1;
          m_pend <= ref_op(op, in_a, in_b);
        end
      end else if (m_age == W + 2) begin
        m_age <= 0;
      end else begin
        m_age <= m_age + 1;
        if (m_age == W + 1) m_out <= m_pend;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_in) begin
    if (en) begin
      check("busy",      busy,      (m_age >= 1 && m_age <= W + 1));
      check("done",      done,      (m_age == W + 2));
      check("result",    result,    m_out.res);
      check("carry_out", carry_out, m_out.carry);
      check("sign0",     sign0,     m_out.sign);
      check("dis1",      dis1,      ((m_edges / SD) % 2));
      check("dis0",      dis0,      !((m_edges / SD) % 2));
      if (done === 1'b1) dut_dones++;
    end
  end

  // One operation; operands/op are scrambled after acceptance.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int n;
    int bc;
    @(negedge clk_in);
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(negedge clk_in);
    start = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); op = 1'($urandom);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      if (noise) start = 1'($urandom);
      @(negedge clk_in);
      n++;
    end
    start = 1'b0;
    check("latency", n, W + 1);
    check("busy_cycles", bc, W + 1);
    @(negedge clk_in);
  endtask

  initial begin
    int d0;
    int tog;
    logic prev;

    // Model pins, hand-computed.
    check("model_add_9_8",  ref_op(1'b0, 4'd9, 4'd8),  {4'h1, 1'b1, 1'b1});
    check("model_sub_3_7",  ref_op(1'b1, 4'd3, 4'd7),  {4'h4, 1'b0, 1'b0});
    check("model_sub_5_5",  ref_op(1'b1, 4'd5, 4'd5),  {4'h0, 1'b0, 1'b1});
    check("model_add_7_8",  ref_op(1'b0, 4'd7, 4'd8),  {4'hf, 1'b0, 1'b1});

    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    en  = 1'b1;
    rst = 1'b0;

    // Reset mid-scan.
    repeat (6) @(negedge clk_in);
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 4'h0);
    check("rst_carry", carry_out, 1'b0);
    check("rst_sign0", sign0, 1'b1);
    check("rst_dis0", dis0, 1'b1);
    check("rst_dis1", dis1, 1'b0);
    rst = 1'b0;

    run_op(1'b0, 4'd9, 4'd8, 1'b0);
    check("add_9_8_res", result, 4'h1);
    check("add_9_8_cy", carry_out, 1'b1);
    check("add_9_8_sg", sign0, 1'b1);

    run_op(1'b1, 4'd3, 4'd7, 1'b0);
    check("sub_3_7_res", result, 4'h4);
    check("sub_3_7_sg", sign0, 1'b0);
    check("sub_3_7_cy", carry_out, 1'b0);
    run_op(1'b1, 4'd7, 4'd3, 1'b0);
    check("sub_7_3_res", result, 4'h4);
    check("sub_7_3_sg", sign0, 1'b1);

    run_op(1'b1, 4'd5, 4'd5, 1'b0);
    check("sub_5_5_res", result, 4'h0);
    check("sub_5_5_sg", sign0, 1'b1);
    check("sub_5_5_cy", carry_out, 1'b0);
    run_op(1'b1, 4'd15, 4'd0, 1'b0);
    check("sub_15_0_res", result, 4'hf);
    check("sub_15_0_sg", sign0, 1'b1);

    // Start pulses at edges 2 and 3, and during DONE, are ignored.
    d0 = dut_dones;
    @(negedge clk_in); start = 1'b1; op = 1'b0; in_a = 4'd3; in_b = 4'd4;
    @(negedge clk_in); start = 1'b0;
    @(negedge clk_in); start = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in); start = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("ign_done_now", done, 1'b1);
    start = 1'b1;
    @(negedge clk_in); start = 1'b0;
    repeat (6) @(negedge clk_in);
    check("ign_one_done", dut_dones - d0, 1);
    check("ign_res", result, 4'h7);

    // Reset at edge 3 aborts the operation.
    d0 = dut_dones;
    @(negedge clk_in); start = 1'b1; op = 1'b0; in_a = 4'd2; in_b = 4'd3;
    @(negedge clk_in); start = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in); rst = 1'b1;
    @(negedge clk_in); rst = 1'b0;
    repeat (8) @(negedge clk_in);
    check("abort_no_done", dut_dones - d0, 0);
    check("abort_res", result, 4'h0);
    check("abort_busy", busy, 1'b0);

    // Operands scrambled mid-op (run_op does this) must not matter.
    run_op(1'b1, 4'd12, 4'd5, 1'b0);
    check("midchg_res", result, 4'h7);
    check("midchg_sg", sign0, 1'b1);

    // Randomized operations with random gaps and start noise while busy.
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
      run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    // Scan strobes: 16 cycles give exactly 4 toggles.
    tog  = 0;
    prev = dis1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (dis1 !== prev) tog++;
      prev = dis1;
    end
    check("scan_toggles", tog, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
